gamepad_pmod_driver: RTL and testbench

// Transmit side of the gamepad Pmod link: serialises a 12-button snapshot onto

---
 rtl/gamepad_pmod_driver.sv | 121 ++++++++++++
 tb/tb_gamepad_pmod_driver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_driver.sv
// Gamepad Pmod transmitter: serialises a 12-button snapshot as latch/clk/data frames
// so the gamepad receiver can be exercised in simulation or on FPGA without the board.
module gamepad_pmod_driver #(
  parameter int HALF_BIT  = 4,
  parameter int LATCH_CYC = 8,
  parameter int FRAME_GAP = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_present,
  input  logic [11:0] i_buttons,
  output logic        pmod_latch,
  output logic        pmod_clk,
  output logic        pmod_data,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int PH_MAX = (LATCH_CYC > HALF_BIT) ? LATCH_CYC : HALF_BIT;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int GAP_W  = $clog2(FRAME_GAP + 1);

  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(LATCH_CYC - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(FRAME_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(FRAME_GAP);
  localparam logic [4:0]       LAST_BIT   = 5'd23;

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t             r_state;
  logic [PH_W-1:0]    r_phaseCnt;
  logic [GAP_W-1:0]   r_gapCnt;
  logic [4:0]         r_bitCnt;
  logic [22:0]        r_shift;

  logic [23:0]        w_snapshot;
  logic               w_gapDone;

  assign w_snapshot = i_present ? {i_buttons, 12'h000} : 24'hFFFFFF;
  assign w_gapDone  = (r_gapCnt == GAP_LAST) || (r_gapCnt == GAP_MAX);

  // pmod_data is the top bit of the 24-bit frame; r_shift holds the 23 bits still to go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_phaseCnt   <= '0;
      r_gapCnt     <= '0;
      r_bitCnt     <= '0;
      r_shift      <= '0;
      pmod_latch   <= 1'b0;
      pmod_clk     <= 1'b0;
      pmod_data    <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_gapCnt != GAP_MAX) r_gapCnt <= r_gapCnt + 1'b1;
          if (w_gapDone && i_enable) begin
            r_state    <= LATCH;
            r_shift    <= w_snapshot[22:0];
            pmod_data  <= w_snapshot[23];
            pmod_latch <= 1'b1;
            o_busy     <= 1'b1;
            r_phaseCnt <= '0;
            r_bitCnt   <= '0;
          end
        end
        LATCH: begin
          if (r_phaseCnt == LATCH_LAST) begin
            r_state    <= LOW;
            pmod_latch <= 1'b0;
            r_phaseCnt <= '0;
          end else begin
            r_phaseCnt <= r_phaseCnt + 1'b1;
          end
        end
        LOW: begin
          if (r_phaseCnt == HALF_LAST) begin
            r_state    <= HIGH;
            pmod_clk   <= 1'b1;
            r_phaseCnt <= '0;
          end else begin
            r_phaseCnt <= r_phaseCnt + 1'b1;
          end
        end
        // Data only moves on the falling clk edge, so it is settled for the receiver's rising edge.
        HIGH: begin
          if (r_phaseCnt == HALF_LAST) begin
            r_phaseCnt <= '0;
            pmod_clk   <= 1'b0;
            if (r_bitCnt == LAST_BIT) begin
              r_state      <= DONE;
              pmod_data    <= 1'b0;
              o_busy       <= 1'b0;
              o_frame_done <= 1'b1;
              r_gapCnt     <= '0;
            end else begin
              r_state   <= LOW;
              pmod_data <= r_shift[22];
              r_shift   <= {r_shift[21:0], 1'b1};
              r_bitCnt  <= r_bitCnt + 5'd1;
            end
          end else begin
            r_phaseCnt <= r_phaseCnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_driver.sv
// Bench for gamepad_pmod_driver: decodes the serial stream like a receiver and compares
// each frame and its timing against a frame-level model built from the applied inputs.
module tb_gamepad_pmod_driver;

  localparam int HALF_BIT  = 4;
  localparam int LATCH_CYC = 8;
  localparam int FRAME_GAP = 64;
  localparam int FRAME_LEN = LATCH_CYC + 48 * HALF_BIT;
  localparam int PERIOD    = FRAME_LEN + 1 + FRAME_GAP;

  localparam logic [11:0] T1_BUTTONS = 12'b1000_0000_0001;
  localparam logic [11:0] T3_OLD     = 12'hA5C;
  localparam logic [11:0] T3_NEW     = 12'h3A1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        present = 1'b1;
  logic [11:0] buttons = T1_BUTTONS;

  logic latch, pclk, data, busy, done;
  logic latch2, pclk2, data2, busy2, done2;

  always #5 clk = ~clk;

  gamepad_pmod_driver #(.HALF_BIT(HALF_BIT), .LATCH_CYC(LATCH_CYC), .FRAME_GAP(FRAME_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_present(present), .i_buttons(buttons),
    .pmod_latch(latch), .pmod_clk(pclk), .pmod_data(data), .o_busy(busy), .o_frame_done(done)
  );

  gamepad_pmod_driver #(.HALF_BIT(2), .LATCH_CYC(1), .FRAME_GAP(1)) dutFast (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_present(present), .i_buttons(buttons),
    .pmod_latch(latch2), .pmod_clk(pclk2), .pmod_data(data2), .o_busy(busy2), .o_frame_done(done2)
  );

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, observed, expected, $time);
  endtask

  // What a receiver should decode from a frame latched with these inputs.
  function automatic logic [23:0] expectedWord(input logic p, input logic [11:0] b);
    return p ? {b, 12'h000} : 24'hFFFFFF;
  endfunction

  // Receiver-side monitor for the default-parameter instance.
  int          cyc = 0;
  int          relCyc = 0;
  int          latchRiseCyc = 0;
  int          doneCyc = -1;
  int          latchCount = 0;
  int          doneCount = 0;
  int          rises = 0;
  int          lastPeriod = 0;
  logic [23:0] rxWord = '0;
  logic [23:0] lastRxWord = '0;
  logic        inFrame = 1'b0;
  logic        enableHeld = 1'b0;
  logic        firstAfterReset = 1'b0;
  logic        prevLatch = 1'b0, prevClk = 1'b0, prevData = 1'b0, prevDone = 1'b0, prevRst = 1'b0;
  logic        prevPresent = 1'b0;
  logic [11:0] prevButtons = '0;
  logic [23:0] expQ[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      inFrame    = 1'b0;
      rises      = 0;
      enableHeld = 1'b0;
      doneCyc    = -1;
      expQ.delete();
      checkOutput("resetOutputs", {latch, pclk, data, busy, done}, 0);
    end else begin
      if (!prevRst) begin
        relCyc          = cyc;
        enableHeld      = enable;
        firstAfterReset = 1'b1;
      end
      if (!enable) enableHeld = 1'b0;
      if (latch && !prevLatch) begin
        latchCount++;
        if (firstAfterReset) begin
          if (enableHeld) checkOutput("resetGap", cyc - relCyc, FRAME_GAP);
          else            checkOutput("resetGapMin", (cyc - relCyc) >= FRAME_GAP, 1);
        end else if (doneCyc >= 0) begin
          if (enableHeld) checkOutput("idleGap", cyc - doneCyc, FRAME_GAP + 1);
          else            checkOutput("idleGapMin", (cyc - doneCyc) >= FRAME_GAP + 1, 1);
        end
        firstAfterReset = 1'b0;
        expQ.push_back(expectedWord(prevPresent, prevButtons));
        latchRiseCyc = cyc;
        inFrame      = 1'b1;
        rises        = 0;
        rxWord       = '0;
      end
      if (!latch && prevLatch) checkOutput("latchWidth", cyc - latchRiseCyc, LATCH_CYC);
      if (pclk && !prevClk) begin
        rises++;
        rxWord = {rxWord[22:0], data};
        checkOutput("dataStable", data, prevData);
      end
      if (pclk && prevClk) checkOutput("dataHold", data, prevData);
      if (done) begin
        checkOutput("donePulse", prevDone, 0);
        checkOutput("bitCount", rises, 24);
        checkOutput("frameLen", cyc - latchRiseCyc, FRAME_LEN);
        checkOutput("doneIdle", {latch, pclk, data}, 0);
        checkOutput("expQueue", expQ.size(), 1);
        if (expQ.size() > 0) checkOutput("word", rxWord, expQ.pop_front());
        if (doneCyc >= 0 && enableHeld) begin
          lastPeriod = cyc - doneCyc;
          checkOutput("period", lastPeriod, PERIOD);
        end
        lastRxWord = rxWord;
        doneCyc    = cyc;
        doneCount++;
        inFrame    = 1'b0;
        enableHeld = enable;
      end
      checkOutput("busy", busy, inFrame);
    end
    prevLatch   = latch;
    prevClk     = pclk;
    prevData    = data;
    prevDone    = done;
    prevRst     = rst_n;
    prevPresent = present;
    prevButtons = buttons;
  end

  // Monitor for the minimum-parameter instance: stream integrity only.
  int          rises2 = 0;
  logic [23:0] rxWord2 = '0;
  logic        prevLatch2 = 1'b0, prevClk2 = 1'b0, prevData2 = 1'b0, prevPresent2 = 1'b0;
  logic [11:0] prevButtons2 = '0;
  logic [23:0] expQ2[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rises2 = 0;
      expQ2.delete();
      checkOutput("resetOutputsFast", {latch2, pclk2, data2, busy2, done2}, 0);
    end else begin
      if (latch2 && !prevLatch2) begin
        expQ2.push_back(expectedWord(prevPresent2, prevButtons2));
        rises2  = 0;
        rxWord2 = '0;
      end
      if (pclk2 && !prevClk2) begin
        rises2++;
        rxWord2 = {rxWord2[22:0], data2};
        checkOutput("dataStableFast", data2, prevData2);
      end
      if (done2) begin
        checkOutput("bitCountFast", rises2, 24);
        checkOutput("expQueueFast", expQ2.size(), 1);
        if (expQ2.size() > 0) checkOutput("wordFast", rxWord2, expQ2.pop_front());
      end
    end
    prevLatch2   = latch2;
    prevClk2     = pclk2;
    prevData2    = data2;
    prevPresent2 = present;
    prevButtons2 = buttons;
  end

  task automatic applyStimulus(input logic [11:0] b, input logic p, input logic e);
    @(posedge clk);
    #2;
    buttons = b;
    present = p;
    enable  = e;
  endtask

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic waitForDone(input int maxCyc);
    int start = doneCount;
    int n = 0;
    while (doneCount == start && n < maxCyc) begin
      waitNeg();
      n++;
    end
    checkOutput("doneTimeout", doneCount != start, 1);
  endtask

  task automatic waitForLatch(input int maxCyc);
    int start = latchCount;
    int n = 0;
    while (latchCount == start && n < maxCyc) begin
      waitNeg();
      n++;
    end
    checkOutput("latchTimeout", latchCount != start, 1);
  endtask

  initial begin
    int n;
    int lc;
    logic [11:0] rb;
    #3;
    checkOutput("resetStart", {latch, pclk, data, busy, done}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single known pattern: B and R pressed.
    waitForDone(FRAME_GAP + FRAME_LEN + 20);
    checkOutput("T1word", lastRxWord, 24'h801000);

    // Empty port: all ones, back-to-back frames one period apart.
    applyStimulus(T1_BUTTONS, 1'b0, 1'b1);
    waitForDone(PERIOD + 20);
    checkOutput("T2word", lastRxWord, 24'hFFFFFF);
    waitForDone(PERIOD + 20);
    checkOutput("T2wordAgain", lastRxWord, 24'hFFFFFF);
    checkOutput("T2period", lastPeriod, PERIOD);

    // Buttons changing mid-frame only show up in the following frame.
    applyStimulus(T3_OLD, 1'b1, 1'b1);
    waitForLatch(PERIOD + 20);
    repeat (100) waitNeg();
    applyStimulus(T3_NEW, 1'b1, 1'b1);
    waitForDone(PERIOD);
    checkOutput("T3oldFrame", lastRxWord, {T3_OLD, 12'h000});
    waitForDone(PERIOD + 20);
    checkOutput("T3newFrame", lastRxWord, {T3_NEW, 12'h000});

    // Enable dropped at the 5th bit: frame completes, then the link stays quiet.
    waitForLatch(PERIOD + 20);
    n = 0;
    while (rises < 5 && n < FRAME_LEN) begin
      waitNeg();
      n++;
    end
    applyStimulus(T3_NEW, 1'b1, 1'b0);
    waitForDone(FRAME_LEN + 20);
    lc = latchCount;
    repeat (600) waitNeg();
    checkOutput("T4quiet", latchCount, lc);
    checkOutput("T4latchLow", latch, 0);
    applyStimulus(T1_BUTTONS, 1'b1, 1'b1);
    waitNeg();
    checkOutput("T4noEarlyLatch", latch, 0);
    waitNeg();
    checkOutput("T4restart", latch, 1);
    waitForDone(FRAME_LEN + 20);

    // Reset during the high phase of bit 10 clears every output immediately.
    waitForLatch(PERIOD + 20);
    n = 0;
    while (!(rises >= 10 && pclk) && n < FRAME_LEN) begin
      waitNeg();
      n++;
    end
    checkOutput("T5inHigh", {rises >= 10, pclk}, 2'b11);
    #2 rst_n = 1'b0;
    #1 checkOutput("T5resetOutputs", {latch, pclk, data, busy, done}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    waitForLatch(FRAME_GAP + 20);
    waitForDone(FRAME_LEN + 20);

    // Random snapshots with random mid-frame disturbances and enable drops.
    repeat (10) begin
      applyStimulus(12'($urandom), $urandom_range(0, 3) != 0, 1'b1);
      waitForLatch(PERIOD + 20);
      repeat ($urandom_range(1, 150)) waitNeg();
      rb = 12'($urandom);
      applyStimulus(rb, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      waitForDone(FRAME_LEN + 20);
      repeat ($urandom_range(0, 100)) waitNeg();
      applyStimulus(buttons, present, 1'b1);
    end
    waitForDone(PERIOD + 20);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
